// File: rtl/cpu_io_pkg.sv
// Shared encodings for the CPU output-register UART path.
package cpu_io_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int UART_FRAME_BITS = 10;
    localparam int UART_DATA_BITS  = UART_FRAME_BITS - 2;

endpackage

// File: rtl/uart_byte_tx.sv
// Serialises one byte as an 8N1 frame; tx is registered and lags the state by one cycle.
//   state    | meaning
//   ST_IDLE  | line high, waiting for load
//   ST_START | start bit (low)
//   ST_DATA  | data bits, LSB first
//   ST_STOP  | stop bit (high); load at its last cycle chains the next byte with no gap
module uart_byte_tx
    import cpu_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] byte_data,
    output logic       tx,
    output logic       done,
    output logic       idle
);

    localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST = 3'(UART_DATA_BITS - 1);

    uart_state_t   state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    bit_idx, bit_idx_nx;
    logic [7:0]    shift, shift_nx;
    logic          bit_end;

    assign bit_end = (cnt == CNT_LAST);
    assign idle    = (state == ST_IDLE);

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt + 1'b1;
        bit_idx_nx = bit_idx;
        shift_nx   = shift;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nx = '0;
                if (load) begin
                    state_nx = ST_START;
                    shift_nx = byte_data;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_nx   = ST_DATA;
                    cnt_nx     = '0;
                    bit_idx_nx = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_nx   = '0;
                    shift_nx = {1'b0, shift[7:1]};
                    if (bit_idx == BIT_LAST) begin
                        state_nx = ST_STOP;
                    end else begin
                        bit_idx_nx = bit_idx + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    done   = 1'b1;
                    cnt_nx = '0;
                    if (load) begin
                        state_nx = ST_START;
                        shift_nx = byte_data;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_idx <= bit_idx_nx;
            shift   <= shift_nx;
            tx      <= (state == ST_START) ? 1'b0 :
                       (state == ST_DATA)  ? shift[0] : 1'b1;
        end
    end

endmodule

// File: rtl/output_uart_tx.sv
// Buffers CPU output-register words in a small FIFO and sends each as two UART bytes,
// high byte first.
module output_uart_tx
    import cpu_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_valid,
    input  logic [15:0] wr_data,
    output logic        full,
    output logic        empty,
    output logic        busy,
    output logic        overflow_err,
    output logic        tx
);

    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_CNT = (PW + 1)'(FIFO_DEPTH);

    logic [15:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic [7:0]    low_byte, load_byte;
    logic          byte_sel;
    logic          push, pop, load, done, idle;

    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);
    assign busy  = !idle;

    // full is the registered value, so a pop in the same cycle cannot free room for a push
    assign push      = wr_valid && !full;
    assign pop       = idle && !empty;
    assign load      = pop || (done && !byte_sel);
    assign load_byte = pop ? mem[rd_ptr][15:8] : low_byte;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            low_byte     <= '0;
            byte_sel     <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                low_byte <= mem[rd_ptr][7:0];
                byte_sel <= 1'b0;
            end
            if (done && !byte_sel) begin
                byte_sel <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_valid && full) begin
                overflow_err <= 1'b1;
            end
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .byte_data(load_byte),
        .tx       (tx),
        .done     (done),
        .idle     (idle)
    );

endmodule

// File: tb/tb_output_uart_tx.sv
// Directed bench for output_uart_tx: a line monitor decodes tx and results are compared
// against hand-computed bytes and cycle timings.
module tb_output_uart_tx;

    localparam int C = 4;
    localparam int D = 4;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_data  = 16'h0000;
    logic        full, empty, busy, overflow_err, tx;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];
    int          rx_start_q[$];
    logic [15:0] words[$];
    logic        rx_on = 1'b0;
    int          rx_t  = 0;
    logic [7:0]  rx_sh = 8'h00;
    logic        full_seen;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    output_uart_tx #(
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH  (D)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .full        (full),
        .empty       (empty),
        .busy        (busy),
        .overflow_err(overflow_err),
        .tx          (tx)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Line monitor: detect start, sample mid-bit, verify stop.
    always @(negedge clk) begin
        if (reset) begin
            rx_on <= 1'b0;
        end else if (!rx_on) begin
            if (tx === 1'b0) begin
                rx_on <= 1'b1;
                rx_t  <= 1;
                rx_start_q.push_back(cyc);
            end
        end else begin
            rx_t <= rx_t + 1;
            if (rx_t >= C + C/2 && rx_t < 9*C && (rx_t % C) == C/2)
                rx_sh[3'((rx_t - C) / C)] <= tx;
            if (rx_t == 9*C + C/2) begin
                check_eq("stop_bit", {31'd0, tx}, 1);
                rx_q.push_back(rx_sh);
                rx_on <= 1'b0;
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rx_q.delete();
        rx_start_q.delete();
        exp_q.delete();
        words.delete();
    endtask

    task automatic send_all(input int gap);
        full_seen = 1'b0;
        foreach (words[i]) begin
            wr_valid = 1'b1;
            wr_data  = words[i];
            @(negedge clk);
            wr_valid = 1'b0;
            if (full) full_seen = 1'b1;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic expect_words(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(words[i][15:8]);
            exp_q.push_back(words[i][7:0]);
        end
    endtask

    task automatic wait_bytes(input string tag, input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, rx_q.size(), n);
    endtask

    task automatic check_rx(input string tag);
        for (int i = 0; i < exp_q.size(); i++)
            if (i < rx_q.size()) check_eq(tag, {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while ((busy || !empty) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, {31'd0, busy}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int bc;
        int k;
        logic tx_low;

        repeat (3) @(negedge clk);
        check_eq("rst_tx", {31'd0, tx}, 1);
        check_eq("rst_busy", {31'd0, busy}, 0);
        check_eq("rst_full", {31'd0, full}, 0);
        check_eq("rst_empty", {31'd0, empty}, 1);
        check_eq("rst_ovf", {31'd0, overflow_err}, 0);
        do_reset();

        // 1: single word, latency and frame length
        wr_valid = 1'b1;
        wr_data  = 16'hA55A;
        @(negedge clk);
        wr_valid = 1'b0;
        check_eq("t1_empty_n", {31'd0, empty}, 0);
        check_eq("t1_tx_n", {31'd0, tx}, 1);
        @(negedge clk);
        check_eq("t1_busy_n1", {31'd0, busy}, 1);
        check_eq("t1_empty_n1", {31'd0, empty}, 1);
        check_eq("t1_tx_n1", {31'd0, tx}, 1);
        bc = busy ? 1 : 0;
        @(negedge clk);
        check_eq("t1_tx_n2", {31'd0, tx}, 0);
        if (busy) bc++;
        k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
            if (busy) bc++;
        end
        check_eq("t1_busy_cycles", bc, 20*C);
        wait_bytes("t1_rx_count", 2, 50);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        check_rx("t1_rx_byte");
        if (rx_start_q.size() >= 2) check_eq("t1_byte_gap", rx_start_q[1] - rx_start_q[0], 10*C);
        check_eq("t1_empty_end", {31'd0, empty}, 1);

        // 2: four words back-to-back, first pop keeps FIFO below full
        do_reset();
        for (int i = 1; i <= 4; i++) words.push_back(16'(i));
        send_all(0);
        check_eq("t2_full_seen", {31'd0, full_seen}, 0);
        wait_bytes("t2_rx_count", 8, 8*15*C);
        expect_words(4);
        check_rx("t2_rx_byte");
        for (int i = 1; i < 8 && i < rx_start_q.size(); i++)
            check_eq("t2_start_gap", rx_start_q[i] - rx_start_q[i-1], (i % 2) ? 10*C : 10*C + 1);
        wait_idle("t2_idle", 200);
        check_eq("t2_ovf", {31'd0, overflow_err}, 0);

        // 3: six words, sixth is dropped
        do_reset();
        for (int i = 0; i < 6; i++) words.push_back({8'(8'hC0 + i), 8'(8'h30 + i)});
        send_all(0);
        check_eq("t3_full_seen", {31'd0, full_seen}, 1);
        check_eq("t3_ovf", {31'd0, overflow_err}, 1);
        wait_bytes("t3_rx_count", 10, 10*15*C);
        expect_words(5);
        check_rx("t3_rx_byte");
        wait_idle("t3_idle", 200);
        repeat (30*C) @(negedge clk);
        check_eq("t3_no_extra", rx_q.size(), 10);

        // 4: push while full in the same cycle as a pop
        do_reset();
        for (int i = 0; i < 5; i++) words.push_back({8'(8'h70 + i), 8'(8'hE0 + i)});
        send_all(0);
        check_eq("t4_full", {31'd0, full}, 1);
        check_eq("t4_ovf_before", {31'd0, overflow_err}, 0);
        k = 0;
        while (!(!busy && full) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_eq("t4_idle_full", {31'd0, !busy && full}, 1);
        wr_valid = 1'b1;
        wr_data  = 16'hDEAD;
        @(negedge clk);
        wr_valid = 1'b0;
        check_eq("t4_ovf", {31'd0, overflow_err}, 1);
        check_eq("t4_count", {29'd0, dut.count}, D - 1);
        check_eq("t4_full_after", {31'd0, full}, 0);
        wait_bytes("t4_rx_count", 10, 10*15*C);
        expect_words(5);
        check_rx("t4_rx_byte");
        wait_idle("t4_idle", 200);

        // 5: reset in the DATA phase of a low byte
        do_reset();
        for (int i = 0; i < 6; i++) words.push_back({8'(8'h10 + i), 8'(8'h80 + i)});
        send_all(0);
        check_eq("t5_ovf_set", {31'd0, overflow_err}, 1);
        k = 0;
        while (rx_start_q.size() < 2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_eq("t5_low_start", rx_start_q.size(), 2);
        repeat (2*C + 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("t5_tx", {31'd0, tx}, 1);
        check_eq("t5_busy", {31'd0, busy}, 0);
        check_eq("t5_empty", {31'd0, empty}, 1);
        check_eq("t5_ovf", {31'd0, overflow_err}, 0);
        tx_low = 1'b0;
        repeat (30*C) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_low = 1'b1;
        end
        check_eq("t5_tx_quiet", {31'd0, tx_low}, 0);
        check_eq("t5_rx_count", rx_q.size(), 1);
        if (rx_q.size() >= 1) check_eq("t5_rx_high", {24'd0, rx_q[0]}, 32'h10);

        // 6: spaced words, pointer wrap
        do_reset();
        for (int i = 0; i < 2*D + 1; i++) words.push_back(16'(16'h9100 + i * 16'h0111));
        send_all(25*C);
        wait_bytes("t6_rx_count", 2*(2*D + 1), 30*C);
        expect_words(2*D + 1);
        check_rx("t6_rx_byte");
        check_eq("t6_ovf", {31'd0, overflow_err}, 0);
        wait_idle("t6_idle", 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
